tcp_slot_reader: RTL and testbench
==================================

// Module: tcp_slot_reader
// PURPOSE
//  Read side of TCP reassembly slot storage. Accepts cmd_read_packet commands, fetches the stored segment size,
//  then streams the segment's 32-bit words from slot data memory in order, with valid/ready backpressure.
//  After the last word is accepted it releases the slot back to the writer. Sits between slot memories and inspection.
// PARAMETERS
//  NUM_SLOTS_PER_STREAM   4     slots per stream; SLOT_W = clog2(NUM_SLOTS_PER_STREAM)
//  MAX_TCP_SEG_LEN_BYTES  1536  max stored segment; MAX_WORDS = MAX_TCP_SEG_LEN_BYTES/4 (384); WORD_W = clog2(MAX_WORDS)
//  STREAM_ADDR_W          10    stream index width (1024 streams)
// PORTS
//  clk              in   1               single clock
//  reset_n          in   1               asynchronous, active-low reset
//  cmd_valid        in   1               command present
//  cmd_ready        out  1               command accepted when cmd_valid&&cmd_ready
//  cmd_type         in   4               tcp_inspect_cmd_t encoding (0 pass_through, 1 write_packet, 2 read_packet)
//  cmd_stream_addr  in   16              stream index; low STREAM_ADDR_W bits used
//  cmd_slot         in   8               slot index
//  cmd_dir          in   1               direction; echoed on out_dir
//  size_rd_en       out  1               size memory read strobe
//  size_rd_addr     out  STREAM_ADDR_W+SLOT_W  {stream,slot}
//  size_rd_data     in   16              segment size in 4-byte words, valid 1 cycle after size_rd_en
//  data_rd_en       out  1               data memory read strobe
//  data_rd_addr     out  STREAM_ADDR_W+SLOT_W+WORD_W  {stream,slot,word_idx}
//  data_rd_data     in   32              word, valid 1 cycle after data_rd_en
//  out_valid        out  1               output word valid
//  out_ready        in   1               downstream accept
//  out_data         out  32              segment word
//  out_sop/out_eop  out  1               first/last word of segment
//  out_dir          out  1               direction of current segment
//  slot_free_valid  out  1               1-cycle pulse: slot released
//  slot_free_addr   out  STREAM_ADDR_W+SLOT_W  released {stream,slot}
//  err_cmd          out  1               1-cycle pulse: non-read command or slot >= NUM_SLOTS_PER_STREAM dropped
//  err_oversize     out  1               sticky: a size > MAX_WORDS was clamped; cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, output FIFO empty, word counters 0. Reset mid-segment aborts it; no slot release.
//  FSM: IDLE -> SIZE_RD -> SIZE_CAP -> STREAM -> DRAIN -> RELEASE -> IDLE.
//   IDLE: cmd_ready=1. On accept of read_packet with valid slot: latch stream/slot/dir, go SIZE_RD.
//         Any other cmd_type, or invalid slot: consume, pulse err_cmd next cycle, stay IDLE, no memory access.
//   SIZE_RD: size_rd_en=1 for one cycle. SIZE_CAP: capture size_rd_data into len.
//         len = min(size, MAX_WORDS); set err_oversize if clamped.
//         len==0 -> RELEASE directly (no output words). Otherwise -> STREAM.
//   STREAM: 2-entry output FIFO. Issue data_rd_en when (fifo_count + inflight) < 2 and word_idx < len.
//         word_idx increments per read, 0..len-1. Returned data is pushed one cycle after its read.
//         After the last read is issued -> DRAIN.
//   DRAIN: wait until last word accepted (out_valid&&out_ready&&out_eop) -> RELEASE.
//   RELEASE: slot_free_valid=1 for exactly one cycle with latched {stream,slot} -> IDLE.
//  cmd_ready=0 in every state except IDLE; one segment in flight at a time.
//  Output: out_valid = FIFO non-empty. out_data/sop/eop/dir held stable while out_valid&&!out_ready.
//   out_sop on word 0; out_eop on word len-1; len==1 asserts both on the same word.
//  Throughput: with out_ready held 1, one word per cycle after a 3-cycle startup
//   (cmd accept -> SIZE_RD -> SIZE_CAP -> first read); first out_valid at cycle 4 after accept.
//  Backpressure: never more than 2 words buffered or in flight; no data_rd_en while the FIFO would overflow.
//   No word is dropped or duplicated.
//  Widths: word_idx WORD_W+1 bits so it can reach MAX_WORDS without wrap.
//   Addresses are concatenations, no arithmetic carry between fields.
// TESTING
//  1. read_packet stream 5 slot 2 size 4, out_ready=1 -> words at data addrs {5,2,0..3}, sop on w0, eop on w3, slot_free_addr={5,2} pulse once.
//  2. size 1 -> single word with sop=eop=1; size 0 -> no out_valid, slot_free pulse 3 cycles after accept.
//  3. size 6, out_ready toggling 1010..., then held 0 for 5 cycles -> all 6 words in order, data stable while stalled, <=2 reads outstanding.
//  4. cmd_type=pass_through, and read_packet with slot 7 -> err_cmd pulse each, no size_rd_en/data_rd_en, cmd_ready stays 1.
//  5. size_rd_data=1000 -> exactly 384 words streamed, err_oversize=1 and remains set.
//  6. reset_n low at word 3 of 10 -> outputs 0 immediately, no slot_free; next command streams normally from word 0.

Source files
------------

// File: rtl/tcp_slot_reader_if.sv
// Handshake and memory-port bundle for the TCP reassembly slot reader.
// The reader attaches through the slave modport; the surrounding system uses master.
interface tcp_slot_reader_if #(
  parameter int STREAM_ADDR_W = 10,
  parameter int SLOT_W        = 2,
  parameter int WORD_W        = 9
);
  logic                                  cmd_valid;
  logic                                  cmd_ready;
  logic [3:0]                            cmd_type;
  logic [15:0]                           cmd_stream_addr;
  logic [7:0]                            cmd_slot;
  logic                                  cmd_dir;
  logic                                  size_rd_en;
  logic [STREAM_ADDR_W+SLOT_W-1:0]       size_rd_addr;
  logic [15:0]                           size_rd_data;
  logic                                  data_rd_en;
  logic [STREAM_ADDR_W+SLOT_W+WORD_W-1:0] data_rd_addr;
  logic [31:0]                           data_rd_data;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [31:0]                           out_data;
  logic                                  out_sop;
  logic                                  out_eop;
  logic                                  out_dir;
  logic                                  slot_free_valid;
  logic [STREAM_ADDR_W+SLOT_W-1:0]       slot_free_addr;
  logic                                  err_cmd;
  logic                                  err_oversize;

  modport slave (
    input  cmd_valid, cmd_type, cmd_stream_addr, cmd_slot, cmd_dir,
    input  size_rd_data, data_rd_data, out_ready,
    output cmd_ready, size_rd_en, size_rd_addr, data_rd_en, data_rd_addr,
    output out_valid, out_data, out_sop, out_eop, out_dir,
    output slot_free_valid, slot_free_addr, err_cmd, err_oversize
  );

  modport master (
    output cmd_valid, cmd_type, cmd_stream_addr, cmd_slot, cmd_dir,
    output size_rd_data, data_rd_data, out_ready,
    input  cmd_ready, size_rd_en, size_rd_addr, data_rd_en, data_rd_addr,
    input  out_valid, out_data, out_sop, out_eop, out_dir,
    input  slot_free_valid, slot_free_addr, err_cmd, err_oversize
  );
endinterface

// File: rtl/tcp_slot_reader.sv
// Streams one stored TCP segment per read_packet command out of slot memory,
// then hands the slot back to the writer.
module tcp_slot_reader #(
  parameter int NUM_SLOTS_PER_STREAM  = 4,
  parameter int MAX_TCP_SEG_LEN_BYTES = 1536,
  parameter int STREAM_ADDR_W         = 10
) (
  input logic              clk,
  input logic              reset_n,
  tcp_slot_reader_if.slave bus
);
  localparam int SLOT_W    = $clog2(NUM_SLOTS_PER_STREAM);
  localparam int MAX_WORDS = MAX_TCP_SEG_LEN_BYTES / 4;
  localparam int WORD_W    = $clog2(MAX_WORDS);

  localparam logic [3:0]      CMD_READ_PACKET = 4'd2;
  localparam logic [7:0]      NUM_SLOTS_B     = 8'(NUM_SLOTS_PER_STREAM);
  localparam logic [15:0]     MAX_WORDS_W16   = 16'(MAX_WORDS);
  localparam logic [WORD_W:0] MAX_LEN         = (WORD_W+1)'(MAX_WORDS);
  localparam logic [WORD_W:0] IDX_ONE         = {{WORD_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE, SIZE_RD, SIZE_CAP, STREAM, DRAIN, RELEASE
  } state_t;

  state_t                   state_reg;
  logic [STREAM_ADDR_W-1:0] stream_reg;
  logic [SLOT_W-1:0]        slot_reg;
  logic                     dir_reg;
  logic [WORD_W:0]          len_reg;
  logic [WORD_W:0]          word_idx_reg;
  logic [WORD_W:0]          ret_idx_reg;
  logic                     rd_pending_reg;
  logic                     size_rd_en_reg;
  logic                     slot_free_reg;
  logic                     err_cmd_reg;
  logic                     err_oversize_reg;
  logic                     rd_ptr_reg;
  logic                     wr_ptr_reg;
  logic [1:0]               count_reg;

  // FIFO entry layout: {eop, sop, data}
  logic [33:0] fifo_mem [2];
  logic [33:0] in_entry;
  logic [33:0] head;

  logic            cmd_fire, cmd_ok, clamp;
  logic [WORD_W:0] len_next;
  logic            fifo_empty, out_valid, pop, pop_mem, push_mem, rd_issue;
  logic [2:0]      occ;
  logic            unused_ok;

  assign cmd_fire = bus.cmd_valid && (state_reg == IDLE);
  assign cmd_ok   = (bus.cmd_type == CMD_READ_PACKET) && (bus.cmd_slot < NUM_SLOTS_B);
  assign clamp    = bus.size_rd_data > MAX_WORDS_W16;
  assign len_next = clamp ? MAX_LEN : bus.size_rd_data[WORD_W:0];

  // Returning data falls through to the output when the FIFO is empty,
  // so the first word is visible in the cycle its read data arrives.
  assign in_entry   = {(ret_idx_reg + IDX_ONE == len_reg), (ret_idx_reg == '0), bus.data_rd_data};
  assign fifo_empty = (count_reg == 2'd0);
  assign head       = fifo_empty ? in_entry : fifo_mem[rd_ptr_reg];
  assign out_valid  = !fifo_empty || rd_pending_reg;
  assign pop        = out_valid && bus.out_ready;
  assign pop_mem    = pop && !fifo_empty;
  assign push_mem   = rd_pending_reg && !(fifo_empty && pop);

  // Buffered plus in-flight words minus this cycle's pop must leave room for one more.
  assign occ      = {1'b0, count_reg} + {2'b00, rd_pending_reg};
  assign rd_issue = (state_reg == STREAM) && (word_idx_reg < len_reg)
                    && (occ <= ({2'b00, pop} + 3'd1));

  assign bus.cmd_ready       = (state_reg == IDLE);
  assign bus.size_rd_en      = size_rd_en_reg;
  assign bus.size_rd_addr    = {stream_reg, slot_reg};
  assign bus.data_rd_en      = rd_issue;
  assign bus.data_rd_addr    = {stream_reg, slot_reg, word_idx_reg[WORD_W-1:0]};
  assign bus.out_valid       = out_valid;
  assign bus.out_data        = out_valid ? head[31:0] : 32'd0;
  assign bus.out_sop         = out_valid && head[32];
  assign bus.out_eop         = out_valid && head[33];
  assign bus.out_dir         = out_valid && dir_reg;
  assign bus.slot_free_valid = slot_free_reg;
  assign bus.slot_free_addr  = {stream_reg, slot_reg};
  assign bus.err_cmd         = err_cmd_reg;
  assign bus.err_oversize    = err_oversize_reg;

  assign unused_ok = ^bus.cmd_stream_addr[15:STREAM_ADDR_W];

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo_entry
    logic [33:0] entry_reg;
    always_ff @(posedge clk) begin
      if (push_mem && (wr_ptr_reg == 1'(gi))) begin
        entry_reg <= in_entry;
      end
    end
    assign fifo_mem[gi] = entry_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      stream_reg       <= '0;
      slot_reg         <= '0;
      dir_reg          <= 1'b0;
      len_reg          <= '0;
      word_idx_reg     <= '0;
      ret_idx_reg      <= '0;
      rd_pending_reg   <= 1'b0;
      size_rd_en_reg   <= 1'b0;
      slot_free_reg    <= 1'b0;
      err_cmd_reg      <= 1'b0;
      err_oversize_reg <= 1'b0;
      rd_ptr_reg       <= 1'b0;
      wr_ptr_reg       <= 1'b0;
      count_reg        <= 2'd0;
    end else begin
      size_rd_en_reg <= 1'b0;
      slot_free_reg  <= 1'b0;
      err_cmd_reg    <= 1'b0;
      rd_pending_reg <= rd_issue;
      count_reg      <= count_reg + {1'b0, push_mem} - {1'b0, pop_mem};
      if (rd_issue)       word_idx_reg <= word_idx_reg + IDX_ONE;
      if (rd_pending_reg) ret_idx_reg  <= ret_idx_reg + IDX_ONE;
      if (push_mem)       wr_ptr_reg   <= ~wr_ptr_reg;
      if (pop_mem)        rd_ptr_reg   <= ~rd_ptr_reg;

      case (state_reg)
        IDLE: begin
          if (cmd_fire) begin
            if (cmd_ok) begin
              stream_reg     <= bus.cmd_stream_addr[STREAM_ADDR_W-1:0];
              slot_reg       <= bus.cmd_slot[SLOT_W-1:0];
              dir_reg        <= bus.cmd_dir;
              word_idx_reg   <= '0;
              ret_idx_reg    <= '0;
              size_rd_en_reg <= 1'b1;
              state_reg      <= SIZE_RD;
            end else begin
              err_cmd_reg <= 1'b1;
            end
          end
        end
        SIZE_RD: state_reg <= SIZE_CAP;
        SIZE_CAP: begin
          len_reg <= len_next;
          if (clamp) err_oversize_reg <= 1'b1;
          if (len_next == '0) begin
            slot_free_reg <= 1'b1;
            state_reg     <= RELEASE;
          end else begin
            state_reg <= STREAM;
          end
        end
        STREAM: begin
          if (rd_issue && (word_idx_reg + IDX_ONE == len_reg)) state_reg <= DRAIN;
        end
        DRAIN: begin
          if (pop && head[33]) begin
            slot_free_reg <= 1'b1;
            state_reg     <= RELEASE;
          end
        end
        RELEASE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tcp_slot_reader.sv
// Directed and randomized checks of tcp_slot_reader against a queue-based model
// of the expected segment words, read addresses and slot releases.
module tb_tcp_slot_reader;
  localparam int SAW       = 10;
  localparam int SLOT_W    = 2;
  localparam int WORD_W    = 9;
  localparam int MAX_WORDS = 384;
  localparam int SA_W      = SAW + SLOT_W;
  localparam int DA_W      = SA_W + WORD_W;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  tcp_slot_reader_if #(.STREAM_ADDR_W(SAW), .SLOT_W(SLOT_W), .WORD_W(WORD_W)) bus();

  tcp_slot_reader #(
    .NUM_SLOTS_PER_STREAM(4),
    .MAX_TCP_SEG_LEN_BYTES(1536),
    .STREAM_ADDR_W(SAW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic        dir;
  } word_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int unsigned seed;

  logic [15:0]     size_tbl [4096];
  word_t           exp_q[$];
  logic [DA_W-1:0] exp_rd_q[$];
  logic [SA_W-1:0] exp_size_q[$];
  logic [SA_W-1:0] exp_free_q[$];

  int issued = 0, accepted = 0;
  int free_cnt = 0, err_cnt = 0, size_rd_cnt = 0, data_rd_cnt = 0;
  int free_cyc = 0, err_cyc = 0, first_valid_cyc = 0;
  bit seen_valid = 1'b0;
  bit prev_stall = 1'b0;
  logic [34:0] prev_word;
  int rdy_mode = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [DA_W-1:0] a);
    return (32'(a) * 32'h9E3779B1) ^ seed;
  endfunction

  // Slot memories with one-cycle registered read
  always @(posedge clk) begin
    if (bus.size_rd_en) bus.size_rd_data <= size_tbl[bus.size_rd_addr];
    if (bus.data_rd_en) bus.data_rd_data <= word_of(bus.data_rd_addr);
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ~bus.out_ready;
        2:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    word_t e;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.size_rd_en) begin
        size_rd_cnt++;
        if (exp_size_q.size() == 0) check("size_rd_spurious", 1, 0);
        else check("size_rd_addr", bus.size_rd_addr, exp_size_q.pop_front());
      end
      if (bus.data_rd_en) begin
        data_rd_cnt++;
        issued++;
        if (exp_rd_q.size() == 0) check("data_rd_spurious", 1, 0);
        else check("data_rd_addr", bus.data_rd_addr, exp_rd_q.pop_front());
      end
      if (prev_stall)
        check("stall_hold", {bus.out_valid, bus.out_dir, bus.out_eop, bus.out_sop, bus.out_data},
              {1'b1, prev_word});
      if (bus.out_valid && !seen_valid) begin
        seen_valid = 1'b1;
        first_valid_cyc = cyc;
      end
      if (bus.out_valid && bus.out_ready) begin
        accepted++;
        if (exp_q.size() == 0) check("out_word_spurious", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("out_word", {bus.out_dir, bus.out_eop, bus.out_sop, bus.out_data},
                {e.dir, e.eop, e.sop, e.data});
        end
      end
      if (bus.data_rd_en) check("outstanding_le2", ((issued - accepted) <= 2), 1);
      if (bus.slot_free_valid) begin
        free_cnt++;
        free_cyc = cyc;
        if (exp_free_q.size() == 0) check("slot_free_spurious", 1, 0);
        else check("slot_free_addr", bus.slot_free_addr, exp_free_q.pop_front());
        check("words_before_free", exp_q.size(), 0);
      end
      if (bus.err_cmd) begin
        err_cnt++;
        err_cyc = cyc;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_word  = {bus.out_dir, bus.out_eop, bus.out_sop, bus.out_data};
    end
  end

  task automatic send(input logic [3:0] t, input logic [15:0] st, input logic [7:0] sl,
                      input logic d, output int acc);
    @(posedge clk);
    #1;
    bus.cmd_valid       = 1'b1;
    bus.cmd_type        = t;
    bus.cmd_stream_addr = st;
    bus.cmd_slot        = sl;
    bus.cmd_dir         = d;
    acc = -1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        acc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    if (acc < 0) check("cmd_accept_timeout", 0, 1);
  endtask

  task automatic prep_seg(input logic [SAW-1:0] st, input logic [1:0] sl,
                          input logic [15:0] size, input logic d);
    int len;
    len = (size > MAX_WORDS) ? MAX_WORDS : int'(size);
    size_tbl[{st, sl}] = size;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back('{word_of({st, sl, 9'(i)}), (i == 0), (i == len - 1), d});
      exp_rd_q.push_back({st, sl, 9'(i)});
    end
    exp_size_q.push_back({st, sl});
    exp_free_q.push_back({st, sl});
    seen_valid = 1'b0;
  endtask

  task automatic run_seg(input logic [SAW-1:0] st, input logic [1:0] sl,
                         input logic [15:0] size, input logic d, input bit chk_lat);
    int f0, acc;
    f0 = free_cnt;
    prep_seg(st, sl, size, d);
    send(4'd2, {6'd0, st}, {6'd0, sl}, d, acc);
    for (int k = 0; k < 3000 && free_cnt == f0; k++) @(posedge clk);
    check("seg_release_count", free_cnt - f0, 1);
    check("seg_words_left", exp_q.size(), 0);
    check("seg_reads_left", exp_rd_q.size(), 0);
    if (size == 0) begin
      check("zero_len_free_lat", free_cyc - acc, 3);
      check("zero_len_no_valid", seen_valid, 0);
    end else if (chk_lat) begin
      check("first_valid_lat", first_valid_cyc - acc, 4);
    end
  endtask

  initial begin
    int acc, e0, s0, d0, f0;
    seed = $urandom;
    bus.cmd_valid = 1'b0;
    bus.cmd_type = 4'd0;
    bus.cmd_stream_addr = 16'd0;
    bus.cmd_slot = 8'd0;
    bus.cmd_dir = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_size_rd_en", bus.size_rd_en, 0);
    check("rst_data_rd_en", bus.data_rd_en, 0);
    check("rst_slot_free", bus.slot_free_valid, 0);
    check("rst_err_cmd", bus.err_cmd, 0);
    check("rst_err_oversize", bus.err_oversize, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    reset_n = 1'b1;

    // Basic segment, stream 5 slot 2, four words
    rdy_mode = 0;
    run_seg(10'd5, 2'd2, 16'd4, 1'b1, 1'b1);

    // Single word and empty segment
    run_seg(10'(($urandom_range(0, 1023))), 2'(($urandom_range(0, 3))), 16'd1, 1'b0, 1'b1);
    run_seg(10'd77, 2'd1, 16'd0, 1'b1, 1'b0);

    // Backpressure: toggling, then a long stall
    fork
      run_seg(10'd300, 2'd3, 16'd6, 1'b0, 1'b0);
      begin
        rdy_mode = 1;
        repeat (8) @(posedge clk);
        rdy_mode = 3;
        repeat (5) @(posedge clk);
        rdy_mode = 0;
      end
    join

    // Dropped commands
    e0 = err_cnt; s0 = size_rd_cnt; d0 = data_rd_cnt;
    send(4'd0, 16'd9, 8'd1, 1'b0, acc);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("cmd_ready_after_pass", bus.cmd_ready, 1);
    end
    check("err_cmd_pass_pulse", err_cnt - e0, 1);
    check("err_cmd_pass_lat", err_cyc - acc, 1);
    e0 = err_cnt;
    send(4'd2, 16'd9, 8'd7, 1'b0, acc);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("cmd_ready_after_bad_slot", bus.cmd_ready, 1);
    end
    check("err_cmd_slot_pulse", err_cnt - e0, 1);
    check("err_cmd_slot_lat", err_cyc - acc, 1);
    check("dropped_no_size_rd", size_rd_cnt - s0, 0);
    check("dropped_no_data_rd", data_rd_cnt - d0, 0);
    check("no_oversize_yet", bus.err_oversize, 0);

    // Oversized segment clamps to MAX_WORDS
    rdy_mode = 2;
    run_seg(10'd1023, 2'd0, 16'd1000, 1'b1, 1'b0);
    check("oversize_set", bus.err_oversize, 1);

    // Randomized segments with random backpressure
    for (int n = 0; n < 6; n++) begin
      run_seg(10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3)),
              16'($urandom_range(0, 24)), 1'($urandom_range(0, 1)), 1'b0);
    end
    check("oversize_sticky", bus.err_oversize, 1);

    // Reset in the middle of a ten-word segment
    rdy_mode = 0;
    issued = 0;
    accepted = 0;
    prep_seg(10'd42, 2'd3, 16'd10, 1'b1);
    send(4'd2, 16'd42, 8'd3, 1'b1, acc);
    for (int k = 0; k < 200 && accepted < 3; k++) @(posedge clk);
    check("mid_reset_reached_word3", accepted, 3);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_data_rd_en", bus.data_rd_en, 0);
    check("mid_rst_out_data", bus.out_data, 0);
    check("mid_rst_slot_free", bus.slot_free_valid, 0);
    check("mid_rst_err_oversize", bus.err_oversize, 0);
    exp_q.delete();
    exp_rd_q.delete();
    exp_size_q.delete();
    exp_free_q.delete();
    issued = 0;
    accepted = 0;
    f0 = free_cnt;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    check("mid_rst_no_release", free_cnt - f0, 0);
    run_seg(10'd42, 2'd3, 16'd10, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
